sp_ram_arbiter: RTL and testbench



---
 rtl/sp_ram_pkg.sv | 16 +
 rtl/rr_arb2.sv | 37 +++
 rtl/sp_ram_arbiter.sv | 124 ++++++++++++
 tb/tb_sp_ram_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sp_ram_pkg.sv
// rtl/sp_ram_pkg.sv - shared defaults, state encoding and master indices for sp_ram_arbiter
package sp_ram_pkg;

    localparam int SP_ADDR_W = 9;
    localparam int SP_DATA_W = 32;
    localparam int SP_BE_W   = SP_DATA_W / 8;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    localparam int M0 = 0;
    localparam int M1 = 1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with registered priority, updated on grant
module rr_arb2
    import sp_ram_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // prio_m1 = 1 means master 1 wins a tie
    logic prio_m1;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[M0] && req[M1]) begin
                gnt[M1] = prio_m1;
                gnt[M0] = !prio_m1;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_m1 <= 1'b0;
        end else if (gnt[M0]) begin
            prio_m1 <= 1'b1;
        end else if (gnt[M1]) begin
            prio_m1 <= 1'b0;
        end
    end

endmodule

// File: rtl/sp_ram_arbiter.sv
// rtl/sp_ram_arbiter.sv - two-master round-robin front end for a single-port byte-enabled RAM
module sp_ram_arbiter
    import sp_ram_pkg::*;
#(
    parameter int ADDR_W         = SP_ADDR_W,
    parameter int DATA_W         = SP_DATA_W,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int BE_W          = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [BE_W-1:0]   m0_be,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [BE_W-1:0]   m1_be,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              init_done,
    output logic              ram_ce,
    output logic              ram_oce,
    output logic              ram_wre,
    output logic              ram_reset,
    output logic [ADDR_W-1:0] ram_ad,
    output logic [DATA_W-1:0] ram_din,
    output logic [BE_W-1:0]   ram_byte_en,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_RUN;

    state_t            state, state_next;
    logic [ADDR_W-1:0] clr_cnt;
    logic [1:0]        gnt;
    logic [1:0]        rd_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RESET_STATE;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == S_CLEAR && clr_cnt == CNT_MAX) begin
            state_next = S_RUN;
        end
    end

    // Gating with reset keeps every output quiet while reset is held
    assign init_done = (state == S_RUN) && !reset;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .en    (init_done),
        .req   ({m1_req, m0_req}),
        .gnt   (gnt)
    );

    assign m0_gnt = gnt[M0];
    assign m1_gnt = gnt[M1];

    always_comb begin
        ram_ce      = 1'b0;
        ram_wre     = 1'b0;
        ram_ad      = '0;
        ram_din     = '0;
        ram_byte_en = '0;
        if (!reset && state == S_CLEAR) begin
            ram_ce      = 1'b1;
            ram_wre     = 1'b1;
            ram_ad      = clr_cnt;
            ram_byte_en = '1;
        end else if (gnt[M0]) begin
            ram_ce      = 1'b1;
            ram_wre     = m0_we;
            ram_ad      = m0_addr;
            ram_din     = m0_wdata;
            ram_byte_en = m0_be;
        end else if (gnt[M1]) begin
            ram_ce      = 1'b1;
            ram_wre     = m1_we;
            ram_ad      = m1_addr;
            ram_din     = m1_wdata;
            ram_byte_en = m1_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pend <= 2'b00;
        end else begin
            rd_pend[M0] <= gnt[M0] && !m0_we;
            rd_pend[M1] <= gnt[M1] && !m1_we;
        end
    end

    // A reset arriving while a read is in flight suppresses its response
    assign m0_rvalid = rd_pend[M0] && !reset;
    assign m1_rvalid = rd_pend[M1] && !reset;
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

    assign ram_reset = reset;
    assign ram_oce   = 1'b1;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// tb/tb_sp_ram_arbiter.sv - directed self-checking bench for sp_ram_arbiter
module tb_sp_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [8:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        init_done, ram_ce, ram_oce, ram_wre, ram_reset;
    logic [8:0]  ram_ad;
    logic [31:0] ram_din, ram_dout;
    logic [3:0]  ram_byte_en;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sp_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .init_done(init_done), .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre),
        .ram_reset(ram_reset), .ram_ad(ram_ad), .ram_din(ram_din), .ram_byte_en(ram_byte_en),
        .ram_dout(ram_dout)
    );

    // Behavioural single-port RAM, read latency 1, write-through output
    logic [31:0] mem [0:511];
    always @(posedge clk) begin
        logic [31:0] t;
        if (ram_reset) begin
            ram_dout <= 32'h0;
        end else if (ram_ce) begin
            t = mem[ram_ad];
            if (ram_wre) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byte_en[b]) t[b*8 +: 8] = ram_din[b*8 +: 8];
                mem[ram_ad] <= t;
            end
            ram_dout <= t;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
    endtask

    task automatic req0(input logic we, input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; m0_be = be;
    endtask

    task automatic req1(input logic we, input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
        m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; m1_be = be;
    endtask

    // Runs n clear cycles from the current one, expecting addresses start..start+n-1
    task automatic run_clear(input string tag, input int start, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (!(ram_ce && ram_wre && ram_ad == 9'(start + i) && ram_din == 0 &&
                  ram_byte_en == 4'hF && !init_done && !m0_gnt && !m1_gnt)) bad++;
            step();
        end
        check({tag, "_bad_cycles"}, bad, 0);
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        #1;
        check("rst_gnt", {m1_gnt, m0_gnt}, 0);
        check("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
        check("rst_init_done", init_done, 0);
        check("rst_ram_ce", ram_ce, 0);
        check("rst_ram_reset", ram_reset, 1);
        check("ram_oce", ram_oce, 1);

        // Clear: held m0 request must see no grant for all 512 writes
        reset = 0;
        req0(0, 9'd3, 0, 0);
        #1;
        check("clr_first_ad", ram_ad, 0);
        run_clear("clear", 0, 512);
        #1;
        check("init_done_513", init_done, 1);
        idle();
        #1;
        check("run_idle_ce", ram_ce, 0);

        // Full write from m0, read back by m1
        req0(1, 9'd5, 32'hDEADBEEF, 4'hF);
        #1;
        check("wr5_gnt", {m1_gnt, m0_gnt}, 2'b01);
        check("wr5_wre", ram_wre, 1);
        step();
        idle();
        req1(0, 9'd5, 0, 0);
        #1;
        check("rd5_gnt", {m1_gnt, m0_gnt}, 2'b10);
        check("rd5_wre", ram_wre, 0);
        step();
        idle();
        #1;
        check("rd5_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
        check("rd5_rdata", m1_rdata, 32'hDEADBEEF);
        step();
        check("rd5_rvalid_off", {m1_rvalid, m0_rvalid}, 2'b00);

        // Partial byte write
        req0(1, 9'd7, 32'h11223344, 4'hF);
        step();
        req0(1, 9'd7, 32'h5555AA55, 4'b0010);
        #1;
        check("pw_be", ram_byte_en, 4'b0010);
        step();
        req0(0, 9'd7, 0, 0);
        step();
        idle();
        #1;
        check("pw_rvalid", m0_rvalid, 1);
        check("pw_rdata", m0_rdata, 32'h1122AA44);

        // Prime addr 1/2 (priority now m1 after three m0 grants)
        req0(1, 9'd1, 32'hA1A1A1A1, 4'hF);
        step();
        idle();
        req1(1, 9'd2, 32'hB2B2B2B2, 4'hF);
        step();
        idle();

        // Both requesting reads: strict alternation, response one cycle later
        req0(0, 9'd1, 0, 0);
        req1(0, 9'd2, 0, 0);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt_gnt", {m1_gnt, m0_gnt}, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("alt_ce", ram_ce, 1);
            if (k > 0) begin
                check("alt_rvalid", {m1_rvalid, m0_rvalid}, (k % 2 == 1) ? 2'b01 : 2'b10);
                check("alt_rdata", m0_rdata, (k % 2 == 1) ? 32'hA1A1A1A1 : 32'hB2B2B2B2);
            end
            step();
        end
        idle();
        #1;
        check("alt_last_rvalid", {m1_rvalid, m0_rvalid}, 2'b10);
        check("alt_last_rdata", m1_rdata, 32'hB2B2B2B2);
        step();

        // m1 alone three times, then both: priority back at m0
        req1(0, 9'd2, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("solo_m1_gnt", {m1_gnt, m0_gnt}, 2'b10);
            step();
        end
        req0(0, 9'd1, 0, 0);
        #1;
        check("both_after_solo", {m1_gnt, m0_gnt}, 2'b01);
        step();
        idle();
        step();

        // Reset in the middle of clear restarts from address 0
        reset = 1;
        step();
        reset = 0;
        #1;
        run_clear("clr_a", 0, 200);
        #1;
        check("mid_ad200", ram_ad, 9'd200);
        reset = 1;
        step();
        reset = 0;
        #1;
        check("restart_ad", ram_ad, 0);
        run_clear("clr_b", 0, 512);
        #1;
        check("init_after_restart", init_done, 1);

        // Reset during an outstanding read kills its response
        req0(0, 9'd5, 0, 0);
        #1;
        check("ord_gnt", m0_gnt, 1);
        step();
        idle();
        reset = 1;
        #1;
        check("ord_rvalid", m0_rvalid, 0);
        step();
        reset = 0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
